rx_bpf_pwr_seq: RTL and testbench

//  Power-up/calibration sequencer directly upstream of the BPF. Drives PU_LNA, PU_BPF and CAL_BPF.

---
 rtl/rx_seq_pkg.sv | 51 +++++
 rtl/seq_timer.sv | 29 ++
 rtl/rx_bpf_pwr_seq.sv | 141 ++++++++++++++
 tb/tb_rx_bpf_pwr_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_seq_pkg.sv
// rtl/rx_seq_pkg.sv - shared types, encodings and default timings for the RX/BPF power sequencer
`timescale 1ns/1ps
package rx_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LNA_ON     = 3'd1,
        ST_BPF_SETTLE = 3'd2,
        ST_BPF_CAL    = 3'd3,
        ST_BPF_RESET  = 3'd4,
        ST_READY      = 3'd5,
        ST_FAULT      = 3'd6
    } seq_state_e;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_CAL_TMO  = 2'd1,
        FC_RDY_LOST = 2'd2
    } fault_code_e;

    localparam int unsigned T_LNA_CYC_DEF     = 10;
    localparam int unsigned T_SETTLE_CYC_DEF  = 10;
    localparam int unsigned T_CAL_TMO_CYC_DEF = 60;
    localparam int unsigned MAX_RETRY_DEF     = 2;
    localparam int unsigned CNT_W_DEF         = 8;

    typedef struct packed {
        logic pu_lna;
        logic pu_bpf;
        logic cal_bpf;
        logic rx_ready;
        logic fault;
    } seq_outs_t;

    // Moore output decode shared by the output registers
    function automatic seq_outs_t decode_outs(input seq_state_e st);
        seq_outs_t o;
        o = '0;
        case (st)
            ST_LNA_ON:     o.pu_lna = 1'b1;
            ST_BPF_SETTLE: begin o.pu_lna = 1'b1; o.pu_bpf = 1'b1; end
            ST_BPF_CAL:    begin o.pu_lna = 1'b1; o.pu_bpf = 1'b1; o.cal_bpf = 1'b1; end
            ST_BPF_RESET:  o.pu_lna = 1'b1;
            ST_READY:      begin o.pu_lna = 1'b1; o.pu_bpf = 1'b1; o.rx_ready = 1'b1; end
            ST_FAULT:      o.fault = 1'b1;
            default:       o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// rtl/seq_timer.sv - loadable down-counter flagging expiry when the count reaches one
`timescale 1ns/1ps
module seq_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    // Load on state entry, then count down; parks at zero so an unused timer never wraps
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // A value of one marks the last cycle, so a load of T gives a T-cycle state
    assign expired = (cnt == CNT_W'(1));

endmodule

// File: rtl/rx_bpf_pwr_seq.sv
// rtl/rx_bpf_pwr_seq.sv - LNA/BPF power-up and calibration sequencer with retry and sticky fault
`timescale 1ns/1ps
module rx_bpf_pwr_seq
    import rx_seq_pkg::*;
#(
    parameter int unsigned T_LNA_CYC     = T_LNA_CYC_DEF,
    parameter int unsigned T_SETTLE_CYC  = T_SETTLE_CYC_DEF,
    parameter int unsigned T_CAL_TMO_CYC = T_CAL_TMO_CYC_DEF,
    parameter int unsigned MAX_RETRY     = MAX_RETRY_DEF,
    parameter int unsigned CNT_W         = CNT_W_DEF
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    input  logic       RDY_BPF,
    output logic       PU_LNA,
    output logic       PU_BPF,
    output logic       CAL_BPF,
    output logic       RX_READY,
    output logic       FAULT,
    output logic [1:0] FAULT_CODE,
    output logic [1:0] RETRY_CNT,
    output logic [2:0] STATE
);

    localparam logic [1:0] MAX_R = 2'(MAX_RETRY);

    seq_state_e       state, state_nxt;
    seq_outs_t        outs;
    fault_code_e      fault_code, code_nxt;
    logic [1:0]       retry_cnt, retry_nxt;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_exp;

    seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_exp)
    );

    // Next state, timer loads, retry and fault-code updates; EN low overrides everything
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        retry_nxt = retry_cnt;
        code_nxt  = fault_code;
        if (!EN) begin
            state_nxt = ST_IDLE;
            retry_nxt = '0;
            code_nxt  = FC_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_LNA_ON;
                    tmr_load  = 1'b1;
                    tmr_val   = CNT_W'(T_LNA_CYC);
                    retry_nxt = '0;
                end
                ST_LNA_ON: begin
                    if (tmr_exp) begin
                        state_nxt = ST_BPF_SETTLE;
                        tmr_load  = 1'b1;
                        tmr_val   = CNT_W'(T_SETTLE_CYC);
                    end
                end
                ST_BPF_SETTLE: begin
                    if (tmr_exp) begin
                        state_nxt = ST_BPF_CAL;
                        tmr_load  = 1'b1;
                        tmr_val   = CNT_W'(T_CAL_TMO_CYC);
                    end
                end
                ST_BPF_CAL: begin
                    // ready takes precedence over a timeout in the same cycle
                    if (RDY_BPF) begin
                        state_nxt = ST_READY;
                    end else if (tmr_exp) begin
                        if (retry_cnt < MAX_R) begin
                            state_nxt = ST_BPF_RESET;
                        end else begin
                            state_nxt = ST_FAULT;
                            code_nxt  = FC_CAL_TMO;
                        end
                    end
                end
                ST_BPF_RESET: begin
                    // one-cycle PU_BPF drop reloads the BPF's internal cal counter
                    state_nxt = ST_BPF_SETTLE;
                    tmr_load  = 1'b1;
                    tmr_val   = CNT_W'(T_SETTLE_CYC);
                    if (retry_cnt < MAX_R) begin
                        retry_nxt = retry_cnt + 2'd1;
                    end
                end
                ST_READY: begin
                    if (!RDY_BPF) begin
                        state_nxt = ST_FAULT;
                        code_nxt  = FC_RDY_LOST;
                    end
                end
                ST_FAULT: begin
                    state_nxt = ST_FAULT;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, registered Moore outputs, retry count and fault code
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            outs       <= '0;
            retry_cnt  <= '0;
            fault_code <= FC_NONE;
        end else begin
            state      <= state_nxt;
            outs       <= decode_outs(state_nxt);
            retry_cnt  <= retry_nxt;
            fault_code <= code_nxt;
        end
    end

    assign PU_LNA     = outs.pu_lna;
    assign PU_BPF     = outs.pu_bpf;
    assign CAL_BPF    = outs.cal_bpf;
    assign RX_READY   = outs.rx_ready;
    assign FAULT      = outs.fault;
    assign FAULT_CODE = fault_code;
    assign RETRY_CNT  = retry_cnt;
    assign STATE      = state;

endmodule

// File: tb/tb_rx_bpf_pwr_seq.sv
// tb/tb_rx_bpf_pwr_seq.sv - self-checking bench for rx_bpf_pwr_seq with a behavioural BPF model
`timescale 1ns/1ps
module tb_rx_bpf_pwr_seq;
    import rx_seq_pkg::*;

    localparam int T_LNA       = 10;
    localparam int T_SETTLE    = 10;
    localparam int T_TMO       = 60;
    localparam int N_RETRY     = 2;
    localparam int BPF_CAL_CYC = 40;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       EN;
    logic       RDY_BPF;
    logic       PU_LNA, PU_BPF, CAL_BPF, RX_READY, FAULT;
    logic [1:0] FAULT_CODE, RETRY_CNT;
    logic [2:0] STATE;

    int   total = 0;
    int   bad = 0;
    int   cur_k = 0;
    int   fails = 0;
    logic force_low = 1'b0;

    rx_bpf_pwr_seq u_dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .EN         (EN),
        .RDY_BPF    (RDY_BPF),
        .PU_LNA     (PU_LNA),
        .PU_BPF     (PU_BPF),
        .CAL_BPF    (CAL_BPF),
        .RX_READY   (RX_READY),
        .FAULT      (FAULT),
        .FAULT_CODE (FAULT_CODE),
        .RETRY_CNT  (RETRY_CNT),
        .STATE      (STATE)
    );

    always #100 CLK = ~CLK;

    // BPF model: ready after 40 CAL cycles of a PU_BPF epoch, only on attempts beyond 'fails'
    int   cal_cnt = 0;
    int   attempt = 0;
    logic bpf_rdy = 1'b0;
    logic prev_bpf = 1'b0;
    always @(posedge CLK) begin
        prev_bpf <= PU_BPF;
        if (!PU_LNA) attempt <= 0;
        else if (PU_BPF && !prev_bpf) attempt <= attempt + 1;
        if (!PU_BPF) begin
            cal_cnt <= 0;
            bpf_rdy <= 1'b0;
        end else if (CAL_BPF) begin
            cal_cnt <= cal_cnt + 1;
            if (cal_cnt >= BPF_CAL_CYC && attempt > fails) bpf_rdy <= 1'b1;
        end
    end
    assign RDY_BPF = bpf_rdy & ~force_low;

    // {PU_LNA, PU_BPF, CAL_BPF, RX_READY, FAULT, FAULT_CODE, RETRY_CNT}
    function automatic logic [8:0] dut_vec();
        return {PU_LNA, PU_BPF, CAL_BPF, RX_READY, FAULT, FAULT_CODE, RETRY_CNT};
    endfunction

    // Expected outputs k cycles after the edge that samples EN=1, given f failing attempts
    function automatic logic [8:0] ref_at(input int k, input int f);
        int s, c;
        logic [1:0] r;
        if (k < T_LNA) return 9'b10000_00_00;
        for (int a = 0; a <= N_RETRY; a++) begin
            r = 2'(a);
            s = T_LNA + a * (T_SETTLE + T_TMO + 1);
            c = s + T_SETTLE;
            if (k < c) return {5'b11000, 2'd0, r};
            if (a >= f) begin
                if (k < c + BPF_CAL_CYC + 2) return {5'b11100, 2'd0, r};
                return {5'b11010, 2'd0, r};
            end
            if (k < c + T_TMO) return {5'b11100, 2'd0, r};
            if (a == N_RETRY) return {5'b00001, 2'd1, r};
            if (k == c + T_TMO) return {5'b10000, 2'd0, r};
        end
        return '0;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic bring_up(input int f);
        EN = 1'b0;
        force_low = 1'b0;
        step();
        step();
        fails = f;
        EN = 1'b1;
        step();
        cur_k = 0;
    endtask

    task automatic advance_to(input int k);
        while (cur_k < k) begin
            step();
            cur_k++;
        end
    endtask

    task automatic run_compare(input string tag, input int f, input int last_k);
        check($sformatf("%s_k0", tag), dut_vec(), ref_at(0, f));
        for (int k = 1; k <= last_k; k++) begin
            step();
            cur_k = k;
            check($sformatf("%s_k%0d", tag, k), dut_vec(), ref_at(k, f));
        end
    endtask

    typedef struct {
        int         f;
        int         k;
        logic [8:0] exp;
        string      name;
    } vec_t;

    localparam int N_VEC = 19;
    vec_t tbl [N_VEC];
    int   run_f;

    initial begin
        tbl[0]  = '{0, 0,   9'b10000_00_00, "s1_lna_k0"};
        tbl[1]  = '{0, 9,   9'b10000_00_00, "s1_lna_k9"};
        tbl[2]  = '{0, 10,  9'b11000_00_00, "s1_bpf_k10"};
        tbl[3]  = '{0, 19,  9'b11000_00_00, "s1_settle_k19"};
        tbl[4]  = '{0, 20,  9'b11100_00_00, "s1_cal_k20"};
        tbl[5]  = '{0, 61,  9'b11100_00_00, "s1_cal_k61"};
        tbl[6]  = '{0, 62,  9'b11010_00_00, "s1_ready_k62"};
        tbl[7]  = '{0, 100, 9'b11010_00_00, "s1_ready_k100"};
        tbl[8]  = '{1, 80,  9'b10000_00_00, "s3_reset_k80"};
        tbl[9]  = '{1, 81,  9'b11000_00_01, "s3_settle_k81"};
        tbl[10] = '{1, 132, 9'b11100_00_01, "s3_cal_k132"};
        tbl[11] = '{1, 133, 9'b11010_00_01, "s3_ready_k133"};
        tbl[12] = '{3, 79,  9'b11100_00_00, "s2_cal_k79"};
        tbl[13] = '{3, 80,  9'b10000_00_00, "s2_reset_k80"};
        tbl[14] = '{3, 151, 9'b10000_00_01, "s2_reset_k151"};
        tbl[15] = '{3, 152, 9'b11000_00_10, "s2_settle_k152"};
        tbl[16] = '{3, 221, 9'b11100_00_10, "s2_cal_k221"};
        tbl[17] = '{3, 222, 9'b00001_01_10, "s2_fault_k222"};
        tbl[18] = '{3, 240, 9'b00001_01_10, "s2_fault_k240"};

        RST_N = 1'b0;
        EN = 1'b0;
        step();
        step();
        check("reset_outs", dut_vec(), 9'd0);
        total++;
        if (STATE !== ST_IDLE) begin
            bad++;
            $display("FAIL reset_state: got %0d expected %0d", STATE, ST_IDLE);
        end
        RST_N = 1'b1;
        step();
        check("idle_en0", dut_vec(), 9'd0);

        // table vectors
        run_f = -1;
        for (int i = 0; i < N_VEC; i++) begin
            if (tbl[i].f != run_f || tbl[i].k < cur_k) begin
                bring_up(tbl[i].f);
                run_f = tbl[i].f;
            end
            advance_to(tbl[i].k);
            check(tbl[i].name, dut_vec(), tbl[i].exp);
        end

        // RDY_BPF dropped for one cycle in READY
        bring_up(0);
        advance_to(70);
        force_low = 1'b1;
        step();
        check("s4_rdy_lost", dut_vec(), 9'b00001_10_00);
        force_low = 1'b0;
        step();
        check("s4_sticky", dut_vec(), 9'b00001_10_00);

        // EN low mid-calibration, then full re-run of the nominal timing
        bring_up(0);
        advance_to(30);
        EN = 1'b0;
        step();
        check("s5_en0_cal", dut_vec(), 9'd0);
        step();
        EN = 1'b1;
        step();
        run_compare("s5_rerun", 0, 70);

        // EN low while in FAULT clears fault, code and retry count
        bring_up(3);
        advance_to(230);
        EN = 1'b0;
        step();
        check("s5_en0_fault", dut_vec(), 9'd0);

        // asynchronous reset mid-settle, then restart with EN held high
        bring_up(0);
        advance_to(15);
        #20;
        RST_N = 1'b0;
        #1;
        check("s6_async_rst", dut_vec(), 9'd0);
        #20;
        RST_N = 1'b1;
        step();
        run_compare("s6_restart", 0, 70);

        // randomized bring-ups with random failing-attempt counts and EN drop points
        for (int n = 0; n < 30; n++) begin
            int f, len;
            f = int'($urandom_range(0, 3));
            len = int'($urandom_range(1, 260));
            bring_up(f);
            run_compare($sformatf("rnd%0d_f%0d", n, f), f, len);
            EN = 1'b0;
            step();
            check($sformatf("rnd%0d_drop", n), dut_vec(), 9'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
